// File: rtl/scaler_dsp_out_pkg.sv
// Shared types, sizes and rounding/clamping helpers for the scaler DSP output stage.
// Optional feature macro SCALER_DSP_OUT_SAT_STAT_EN (clamp statistics) is handled in the top.
// Word layout in the output FIFO is {last, pixel_2, pixel_1}.
package scaler_dsp_out_pkg;

  localparam int PIXEL_BITWIDTH  = 8;
  localparam int VRLT_BITWIDTH   = 18;
  localparam int FRAC_BITS       = 6;
  localparam int PACK_NUM        = 4;
  localparam int FIFO_DEPTH      = 16;
  localparam int AFULL_MARGIN    = 4;
  localparam int LINE_W_BITWIDTH = 12;

  localparam int LANE_W     = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam int FIFO_LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W     = 2 * PACK_NUM * PIXEL_BITWIDTH + 1;

  localparam int ROUND_CONST = 2 ** (FRAC_BITS - 1);
  localparam int PIX_MAX     = 2 ** PIXEL_BITWIDTH - 1;

  // Width of the rounded value: one guard bit above the input, fraction removed.
  localparam int RND_W = VRLT_BITWIDTH + 1 - FRAC_BITS;
  localparam logic signed [RND_W-1:0] PIX_MAX_R = RND_W'(PIX_MAX);

  typedef logic [PIXEL_BITWIDTH-1:0]          pix_t;
  typedef logic [PACK_NUM*PIXEL_BITWIDTH-1:0] pix_vec_t;
  typedef logic signed [RND_W-1:0]            rnd_t;

  typedef struct packed {
    logic     last;
    pix_vec_t pixel_2;
    pix_vec_t pixel_1;
  } word_t;

  // Round-half-up then arithmetic shift; the add is one bit wider so it never wraps.
  function automatic rnd_t round_shift(input logic [VRLT_BITWIDTH-1:0] x);
    logic [VRLT_BITWIDTH:0] s;
    s = {x[VRLT_BITWIDTH-1], x} + (VRLT_BITWIDTH+1)'(ROUND_CONST);
    // Taking the top bits of the sign-extended sum is the arithmetic shift.
    return s[VRLT_BITWIDTH:FRAC_BITS];
  endfunction

  // True when the rounded value lies outside the unsigned pixel range.
  function automatic logic clamp_hit(input rnd_t r);
    return r[RND_W-1] || (r > PIX_MAX_R);
  endfunction

  // Clamp a rounded value to 0..PIX_MAX.
  function automatic pix_t clamp_pix(input rnd_t r);
    if (r[RND_W-1]) begin
      return '0;
    end else if (r > PIX_MAX_R) begin
      return pix_t'(PIX_MAX);
    end else begin
      return r[PIXEL_BITWIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/scaler_dsp_out_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered head and level output.
// Latency: a write into an empty FIFO is visible on rd_dat/rd_vld the next cycle; no bypass.
// Backpressure: pops on rd_vld && rd_rdy; writes when full are ignored unless a pop happens.
module scaler_dsp_out_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       afull
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  logic             push;
  logic             pop;
  logic [AW:0]      cnt_nxt;
  logic [AW-1:0]    rd_ptr_nxt;

  assign rd_vld     = (cnt != '0);
  assign pop        = rd_vld && rd_rdy;
  assign push       = wr_vld && ((cnt != (AW+1)'(DEPTH)) || pop);
  assign cnt_nxt    = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign level      = cnt;

  // Storage array; contents need no reset because cnt qualifies them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers, level, registered almost-full and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      afull  <= 1'b0;
      rd_dat <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      afull  <= (cnt_nxt >= (AW+1)'(AFULL_LEVEL));
      // The pushed word becomes the head only when no older word survives this cycle.
      if (cnt_nxt != '0) begin
        rd_dat <= (cnt == (AW+1)'(pop)) ? wr_dat : mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/scaler_dsp_out.sv
// Rounds, clamps and packs scaler DSP sums into multi-pixel words with end-of-line marking.
// Latency: completing din_en at N -> FIFO write at N+3 -> dout_valid at N+4 (empty FIFO).
// Backpressure: dout holds while !dout_ready; din_afull is advisory, full-FIFO words are dropped.
// Optional macro SCALER_DSP_OUT_SAT_STAT_EN adds the stat_sat_cnt clamp counter port.
module scaler_dsp_out
  import scaler_dsp_out_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LINE_W_BITWIDTH-1:0]      cfg_line_width,
  input  logic                            din_en,
  input  logic [VRLT_BITWIDTH-1:0]        din_result_1,
  input  logic [VRLT_BITWIDTH-1:0]        din_result_2,
  output logic                            din_afull,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [PACK_NUM*PIXEL_BITWIDTH-1:0] dout_pixel_1,
  output logic [PACK_NUM*PIXEL_BITWIDTH-1:0] dout_pixel_2,
  output logic                            dout_last,
  output logic                            err_overflow
`ifdef SCALER_DSP_OUT_SAT_STAT_EN
  ,
  output logic [31:0]                     stat_sat_cnt
`endif
);

  // Stage 1: rounded values
  logic  s1_vld;
  rnd_t  s1_r1;
  rnd_t  s1_r2;

  // Stage 2: clamped pixels
  logic  s2_vld;
  pix_t  s2_p1;
  pix_t  s2_p2;

  // Stage 3: packing state and completed word
  logic [LANE_W-1:0]          lane_cnt;
  logic [LINE_W_BITWIDTH-1:0] pix_cnt;
  logic [LINE_W_BITWIDTH-1:0] line_w_q;
  pix_vec_t                   acc_1;
  pix_vec_t                   acc_2;
  logic                       word_vld;
  word_t                      word_q;

  logic [LINE_W_BITWIDTH-1:0] cur_width;
  logic                       is_last;
  logic                       word_done;
  pix_vec_t                   ins_1;
  pix_vec_t                   ins_2;

  // FIFO side
  word_t                      fifo_head;
  logic [FIFO_LVL_W-1:0]      fifo_level;
  logic                       fifo_pop;
  logic                       word_drop;

  // Stage 1: round both sums out of the fixed-point format.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_r1  <= '0;
      s1_r2  <= '0;
    end else begin
      s1_vld <= din_en;
      if (din_en) begin
        s1_r1 <= round_shift(din_result_1);
        s1_r2 <= round_shift(din_result_2);
      end
    end
  end

  // Stage 2: clamp rounded values to the unsigned pixel range.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_p1  <= '0;
      s2_p2  <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_p1 <= clamp_pix(s1_r1);
        s2_p2 <= clamp_pix(s1_r2);
      end
    end
  end

  // Stage 3 combinational: line-end detection and lane insertion.
  always_comb begin
    // A new line latches its width from the config; mid-line uses the latched copy.
    cur_width = (pix_cnt == '0) ? cfg_line_width : line_w_q;
    is_last   = (pix_cnt == (cur_width - LINE_W_BITWIDTH'(1)));
    word_done = (lane_cnt == LANE_W'(PACK_NUM - 1)) || is_last;
    ins_1     = acc_1;
    ins_2     = acc_2;
    ins_1[lane_cnt*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] = s2_p1;
    ins_2[lane_cnt*PIXEL_BITWIDTH +: PIXEL_BITWIDTH] = s2_p2;
  end

  // Stage 3 registers: advance lane/pixel counters and emit completed words.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      pix_cnt  <= '0;
      line_w_q <= '0;
      acc_1    <= '0;
      acc_2    <= '0;
      word_vld <= 1'b0;
      word_q   <= '0;
    end else begin
      word_vld <= s2_vld && word_done;
      if (s2_vld) begin
        if (pix_cnt == '0) begin
          line_w_q <= cfg_line_width;
        end
        if (word_done) begin
          // Accumulator restarts at zero so unused upper lanes of a short word stay 0.
          word_q   <= '{last: is_last, pixel_2: ins_2, pixel_1: ins_1};
          acc_1    <= '0;
          acc_2    <= '0;
          lane_cnt <= '0;
        end else begin
          acc_1    <= ins_1;
          acc_2    <= ins_2;
          lane_cnt <= lane_cnt + LANE_W'(1);
        end
        pix_cnt <= is_last ? '0 : pix_cnt + LINE_W_BITWIDTH'(1);
      end
    end
  end

  assign fifo_pop  = dout_valid && dout_ready;
  assign word_drop = word_vld && (fifo_level == FIFO_LVL_W'(FIFO_DEPTH)) && !fifo_pop;

  scaler_dsp_out_fifo #(
    .WIDTH       (WORD_W),
    .DEPTH       (FIFO_DEPTH),
    .AFULL_LEVEL (FIFO_DEPTH - AFULL_MARGIN)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (word_vld),
    .wr_dat (word_q),
    .rd_vld (dout_valid),
    .rd_rdy (dout_ready),
    .rd_dat (fifo_head),
    .level  (fifo_level),
    .afull  (din_afull)
  );

  assign dout_pixel_1 = fifo_head.pixel_1;
  assign dout_pixel_2 = fifo_head.pixel_2;
  assign dout_last    = fifo_head.last;

  // Sticky overflow flag: set when a completed word finds the FIFO full.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
    end else if (word_drop) begin
      err_overflow <= 1'b1;
    end
  end

`ifdef SCALER_DSP_OUT_SAT_STAT_EN
  logic [1:0] sat_hits;

  // Number of clamped pixels (line 1 + line 2) in the current stage-1 sample.
  always_comb begin
    sat_hits = {1'b0, clamp_hit(s1_r1)} + {1'b0, clamp_hit(s1_r2)};
  end

  // Saturating clamp counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sat_cnt <= '0;
    end else if (s1_vld && (sat_hits != 2'd0)) begin
      if (stat_sat_cnt > (32'hFFFF_FFFF - 32'(sat_hits))) begin
        stat_sat_cnt <= 32'hFFFF_FFFF;
      end else begin
        stat_sat_cnt <= stat_sat_cnt + 32'(sat_hits);
      end
    end
  end
`endif

endmodule

// File: tb/tb_scaler_dsp_out.sv
// Directed bench for scaler_dsp_out: rounding, clamping, packing, latency, backpressure, reset.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Clamp statistics are checked only when SCALER_DSP_OUT_SAT_STAT_EN is defined.
module tb_scaler_dsp_out;
  import scaler_dsp_out_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_line_width;
  logic        din_en;
  logic [17:0] din_result_1;
  logic [17:0] din_result_2;
  logic        din_afull;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_pixel_1;
  logic [31:0] dout_pixel_2;
  logic        dout_last;
  logic        err_overflow;
`ifdef SCALER_DSP_OUT_SAT_STAT_EN
  logic [31:0] stat_sat_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [64:0] got [$];
  int first_af;

  always #5 clk = ~clk;

  scaler_dsp_out dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_line_width (cfg_line_width),
    .din_en         (din_en),
    .din_result_1   (din_result_1),
    .din_result_2   (din_result_2),
    .din_afull      (din_afull),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .dout_pixel_1   (dout_pixel_1),
    .dout_pixel_2   (dout_pixel_2),
    .dout_last      (dout_last),
    .err_overflow   (err_overflow)
`ifdef SCALER_DSP_OUT_SAT_STAT_EN
    ,
    .stat_sat_cnt   (stat_sat_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r1, input int r2);
    din_en       = 1'b1;
    din_result_1 = 18'(r1);
    din_result_2 = 18'(r2);
    step();
  endtask

  // Pixel p on line 1 and q on line 2, encoded as exact 8Q6 values.
  task automatic drive_px(input int p, input int q);
    drive(p * 64, q * 64);
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    din_en     = 1'b0;
    dout_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int k = 0;
    while (!dout_valid && k < bound) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 64'(dout_valid), 64'd1);
  endtask

  task automatic drain(input int bound);
    got.delete();
    dout_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (dout_valid) got.push_back({dout_last, dout_pixel_2, dout_pixel_1});
      step();
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Lanes base..base+3 (line 1) or 255-(base..base+3) (line 2).
  function automatic logic [31:0] seq_word(input int base, input bit inv);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) w[l*8 +: 8] = inv ? 8'(255 - (base + l)) : 8'(base + l);
    return w;
  endfunction

  task automatic check_stream(input string tag, input int n_words);
    logic [64:0] w;
    check({tag, "_count"}, 64'(got.size()), 64'(n_words));
    for (int k = 0; k < n_words; k++) begin
      w = (k < got.size()) ? got[k] : 65'bx;
      check({tag, "_p1"},   64'(w[31:0]),  64'(seq_word(4 * k, 1'b0)));
      check({tag, "_p2"},   64'(w[63:32]), 64'(seq_word(4 * k, 1'b1)));
      check({tag, "_last"}, 64'(w[64]),    64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; din_en = 1'b0; din_result_1 = '0; din_result_2 = '0;
    dout_ready = 1'b0; cfg_line_width = 12'd4;
    step();
    step();
    // Reset state
    check("rst_valid", 64'(dout_valid),   64'd0);
    check("rst_last",  64'(dout_last),    64'd0);
    check("rst_p1",    64'(dout_pixel_1), 64'd0);
    check("rst_p2",    64'(dout_pixel_2), 64'd0);
    check("rst_afull", 64'(din_afull),    64'd0);
    check("rst_ovf",   64'(err_overflow), 64'd0);
    rst = 1'b0;
`ifdef SCALER_DSP_OUT_SAT_STAT_EN
    check("rst_stat", 64'(stat_sat_cnt), 64'd0);
`endif

    // Saturation, including the extreme 18-bit inputs; width 4 so the word is a line end
    dout_ready = 1'b1;
    drive(16383, 0); drive(-16384, 0); drive(131071, 0); drive(-131072, 0);
    din_en = 1'b0;
    wait_valid("sat", 10);
    check("sat_p1",   64'(dout_pixel_1), 64'(pack4(255, 0, 255, 0)));
    check("sat_p2",   64'(dout_pixel_2), 64'd0);
    check("sat_last", 64'(dout_last),    64'd1);
`ifdef SCALER_DSP_OUT_SAT_STAT_EN
    check("sat_stat", 64'(stat_sat_cnt), 64'd4);
`endif
    step();

    // Rounding: 95,96,-33,-32 -> 1,2,0,0 ; 0,64,128,192 -> 0,1,2,3
    drive(95, 0); drive(96, 64); drive(-33, 128); drive(-32, 192);
    din_en = 1'b0;
    wait_valid("rnd", 10);
    check("rnd_p1",   64'(dout_pixel_1), 64'(pack4(1, 2, 0, 0)));
    check("rnd_p2",   64'(dout_pixel_2), 64'(pack4(0, 1, 2, 3)));
    check("rnd_last", 64'(dout_last),    64'd1);
`ifdef SCALER_DSP_OUT_SAT_STAT_EN
    check("rnd_stat", 64'(stat_sat_cnt), 64'd5);
`endif
    step();

    // Partial last word and exact latency: width 6, pixels 10..15
    reset_dut();
    cfg_line_width = 12'd6;
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive_px(10 + i, 110 + i);
    din_en = 1'b0;
    check("lat_early", 64'(dout_valid), 64'd0);
    step();
    check("w0_valid", 64'(dout_valid),   64'd1);
    check("w0_p1",    64'(dout_pixel_1), 64'(pack4(10, 11, 12, 13)));
    check("w0_p2",    64'(dout_pixel_2), 64'(pack4(110, 111, 112, 113)));
    check("w0_last",  64'(dout_last),    64'd0);
    step();
    check("gap_valid", 64'(dout_valid),  64'd0);
    step();
    check("w1_valid", 64'(dout_valid),   64'd1);
    check("w1_p1",    64'(dout_pixel_1), 64'(pack4(14, 15, 0, 0)));
    check("w1_p2",    64'(dout_pixel_2), 64'(pack4(114, 115, 0, 0)));
    check("w1_last",  64'(dout_last),    64'd1);
    step();

    // Back-pressure: stop input 5 cycles after din_afull -> 56 pixels, 14 words, no loss
    reset_dut();
    cfg_line_width = 12'd200;
    first_af = -1;
    for (int j = 0; j < 80; j++) begin
      if (din_afull && first_af < 0) first_af = j;
      if (first_af >= 0 && j >= first_af + 5) din_en = 1'b0;
      else drive_px(j, 255 - j);
      if (!din_en) step();
    end
    din_en = 1'b0;
    check("bp_afull_cycle", 64'(first_af),     64'd51);
    check("bp_ovf",         64'(err_overflow), 64'd0);
    check("bp_hold_p1",     64'(dout_pixel_1), 64'(seq_word(0, 1'b0)));
    drain(40);
    check_stream("bp", 14);
    check("bp_afull_drained", 64'(din_afull), 64'd0);

    // Overflow: 100 pixels into a stalled FIFO -> first 16 words kept, 9 dropped
    reset_dut();
    cfg_line_width = 12'd100;
    for (int j = 0; j < 100; j++) drive_px(j, 255 - j);
    din_en = 1'b0;
    for (int j = 0; j < 10; j++) step();
    check("ovf_flag",  64'(err_overflow), 64'd1);
    check("ovf_afull", 64'(din_afull),    64'd1);
    drain(40);
    check_stream("ovf", 16);
    check("ovf_sticky", 64'(err_overflow), 64'd1);

    // Reset mid-line: word held on the output plus 2 pixels of the next word pending
    reset_dut();
    cfg_line_width = 12'd8;
    for (int i = 0; i < 6; i++) drive_px(40 + i, 215 - i);
    din_en = 1'b0;
    step();
    check("mid_pre_valid", 64'(dout_valid),   64'd1);
    check("mid_pre_p1",    64'(dout_pixel_1), 64'(pack4(40, 41, 42, 43)));
    rst = 1'b1;
    step();
    check("mid_rst_valid", 64'(dout_valid),   64'd0);
    check("mid_rst_p1",    64'(dout_pixel_1), 64'd0);
    check("mid_rst_p2",    64'(dout_pixel_2), 64'd0);
    check("mid_rst_last",  64'(dout_last),    64'd0);
    check("mid_rst_afull", 64'(din_afull),    64'd0);
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_px(60 + i, 195 - i);
    din_en = 1'b0;
    wait_valid("mid", 10);
    check("mid_p1",   64'(dout_pixel_1), 64'(seq_word(60, 1'b0)));
    check("mid_p2",   64'(dout_pixel_2), 64'(seq_word(60, 1'b1)));
    check("mid_last", 64'(dout_last),    64'd0);
    step();
    drain(12);
    check("mid_extra_words", 64'(got.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scaler_dsp_out.md
# scaler_dsp_out

Post-processing stage directly downstream of the scaler DSP processing unit. It accepts the two signed filter sums per cycle (line 1 and line 2), rounds and shifts them out of the coefficient fixed-point format, and clamps them to unsigned pixels. It packs the pixels into multi-pixel words with end-of-line marking and buffers them in a small FIFO. The FIFO drives a valid/ready output and gives an almost-full back-pressure hint to the upstream controller, since the DSP pipeline itself cannot stall.

## Interface
- PIXEL_BITWIDTH, 8, output pixel width (unsigned)
- VRLT_BITWIDTH, 18, input result width (signed, two's complement)
- FRAC_BITS, 6, fractional bits of the result (8Q6 coefficients)
- PACK_NUM, 4, pixels per output word per line
- FIFO_DEPTH, 16, output FIFO depth in words (power of 2)
- AFULL_MARGIN, 4, free words remaining when din_afull asserts
- LINE_W_BITWIDTH, 12, width of the line-width config

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cfg_line_width  in  LINE_W_BITWIDTH  pixels per line, 1..2^LINE_W_BITWIDTH-1
- din_en  in  1  input sample valid
- din_result_1  in  VRLT_BITWIDTH  signed sum, line 1
- din_result_2  in  VRLT_BITWIDTH  signed sum, line 2
- din_afull  out  1  FIFO level ≥ FIFO_DEPTH-AFULL_MARGIN
- dout_valid  out  1  output word valid
- dout_ready  in  1  consumer accepts word
- dout_pixel_1  out  PACK_NUM*PIXEL_BITWIDTH  packed line-1 pixels, lane 0 in LSBs = earliest pixel
- dout_pixel_2  out  PACK_NUM*PIXEL_BITWIDTH  packed line-2 pixels, same lane order
- dout_last  out  1  word holds the last pixel of a line
- err_overflow  out  1  sticky: word dropped because the FIFO was full

## Operation
- **Stage 1 (round):** `r = (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS`.
  - The add is computed at VRLT_BITWIDTH+1 bits so it never wraps.
  - The shift is arithmetic.
- **Stage 2 (clamp):**
  - r < 0 → 0.
  - r > 2^PIXEL_BITWIDTH-1 → 2^PIXEL_BITWIDTH-1.
  - Otherwise r.
- **Stage 3 (pack):**
  - Lane counter 0..PACK_NUM-1 and pixel counter 0..cfg_line_width-1.
  - Each valid pixel pair writes lane[lane_cnt].
  - A word completes when lane_cnt = PACK_NUM-1, or when the pixel is the last of the line.
  - On the last pixel of a line, unused higher lanes are zero and dout_last=1. Both counters then return to 0.
  - cfg_line_width is sampled only when the pixel counter is 0. Mid-line changes take effect on the next line.
- **FIFO:** synchronous, first-word-fall-through, with a registered output.
  - Read when dout_valid && dout_ready.
  - A write is accepted when not full, or when full with a read in the same cycle.
  - Otherwise the word is dropped and err_overflow is set; it clears only on rst.
- **Output hold:** dout_* is held stable while dout_valid && !dout_ready.
- **din_afull:** advisory only. Upstream must stop issuing din_en early enough to cover the 3-cycle pipeline plus in-flight DSP samples.

## Timing
- **Reset:** on rst=1 at a clock edge:
  - Outputs dout_valid, dout_last, din_afull and err_overflow are 0; dout_pixel_* are 0.
  - The counters, FIFO pointers and the partial word are cleared.
  - Pipeline stages are invalidated. Data in flight mid-line is discarded, and the next pixel starts lane 0 of a new line.
- **Latency:** din_en for the completing pixel at cycle N → word written to the FIFO at N+3 → dout_valid=1 at N+4 if the FIFO was empty.
- **Throughput:** one pixel pair per cycle sustained; one word per PACK_NUM cycles.
- **din_afull:** registered; reflects the FIFO level after the previous cycle's read and write.
- **Empty FIFO:** a simultaneous write and read is not possible (no bypass path).

## Configuration
- SCALER_DSP_OUT_SAT_STAT_EN defined:
  - Adds output port stat_sat_cnt [31:0], which counts clamped pixels (both lines, both directions).
  - Saturates at 2^32-1 and clears on rst.
- Not defined:
  - Port and counter are absent.
  - Data-path behaviour is identical either way.

## Structure
- **Shared package:**
  - Localparams ROUND_CONST = 2^(FRAC_BITS-1) and PIX_MAX = 2^PIXEL_BITWIDTH-1.
  - FIFO word layout: {last, pixel_2, pixel_1}, width 2*PACK_NUM*PIXEL_BITWIDTH+1.
- **Sub-module:** scaler_dsp_out_fifo, a generic synchronous FWFT FIFO with a level output. It is reusable by other scaler stages.

## Test plan
- **Rounding:** results 95, 96, -33, -32 (8Q6) → pixels 1, 2, 0, 0. Here -32 rounds to 0; -33 rounds to -1, which clamps to 0.
- **Saturation:** result 16383 → 255; -16384 → 0. With SCALER_DSP_OUT_SAT_STAT_EN, stat_sat_cnt=2.
- **Partial last word:** cfg_line_width=6, 6 contiguous pixels 10..15 → word 0 lanes {10,11,12,13} with last=0; word 1 lanes {14,15,0,0} with last=1. The first word's dout_valid is 4 cycles after the 4th din_en.
- **Back-pressure:** dout_ready=0 with continuous input.
  - din_afull rises at level 12.
  - Input stopped 5 cycles after din_afull → no overflow.
  - Input continued → err_overflow=1, and exactly the excess words are missing after the drain.
- **Reset mid-line:** rst pulsed after 2 pixels of a line, then 4 new pixels → one word containing only the 4 new pixels; outputs are 0 during rst.
